// File: rtl/tile_game_ctrl_if.sv
// Handshake bundle between the tile game sequencer and its neighbours:
// key/start/bottom-row inputs in, shifter pulses and score/status out.
interface tile_game_ctrl_if #(
  parameter int SCORE_W = 10
);
  logic               start;
  logic [3:0]         key;
  logic [2:0]         bottom_lane;
  logic               shift;
  logic               rows_clear;
  logic [SCORE_W-1:0] score;
  logic [3:0]         level;
  logic               playing;
  logic               game_over;

  modport master (
    output start, key, bottom_lane,
    input  shift, rows_clear, score, level, playing, game_over
  );

  modport slave (
    input  start, key, bottom_lane,
    output shift, rows_clear, score, level, playing, game_over
  );
endinterface

// File: rtl/tile_game_ctrl.sv
// Game sequencer for the 7-row tile shifter: shift/clear pulse generation,
// lane-key judging against the bottom row, score, speed level and game-over.
module tile_game_ctrl #(
  parameter int TICK_INIT   = 25000000,
  parameter int TICK_STEP   = 2000000,
  parameter int TICK_MIN    = 5000000,
  parameter int LEVEL_EVERY = 10,
  parameter int SCORE_W     = 10
) (
  input  logic              clk,
  input  logic              resetn,
  tile_game_ctrl_if.slave   bus
);
  localparam int CNT_W = $clog2(TICK_INIT + 1);
  localparam int LC_W  = $clog2(LEVEL_EVERY + 1);
  localparam int unsigned SPAN = (TICK_INIT > TICK_MIN) ? TICK_INIT - TICK_MIN : 0;

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t           state;
  logic [3:0]       key_q;
  logic             start_q;
  logic             hit;
  logic [LC_W-1:0]  lvl_cnt;
  logic [CNT_W-1:0] tick;

  logic [3:0]       key_rise;
  logic [3:0]       lane_mask;
  logic             start_rise;
  logic             lane_valid;
  logic             correct;
  logic             wrong;
  logic             expiry;
  logic             miss;
  logic [31:0]      reduction;
  logic [CNT_W-1:0] period;

  // One-hot decode of the bottom tile; codes 0 and 5..7 decode to all-zero.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_mask[gi] = (bus.bottom_lane == 3'(gi + 1));
  end

  assign key_rise   = bus.key & ~key_q;
  assign start_rise = bus.start & ~start_q;
  assign lane_valid = |lane_mask;

  // A hit needs exactly the matching lane key to rise, once per tile.
  assign correct = (key_rise != 4'd0) && lane_valid && (key_rise == lane_mask) && !hit;
  assign wrong   = (key_rise != 4'd0) && !correct;
  assign expiry  = (tick == CNT_W'(1));
  assign miss    = expiry && lane_valid && !hit && !correct;

  // Compare before subtracting so a high level never wraps the period.
  assign reduction = 32'(bus.level) * 32'(TICK_STEP);
  assign period    = (reduction >= SPAN) ? CNT_W'(TICK_MIN) : CNT_W'(TICK_INIT - reduction);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      key_q          <= '0;
      start_q        <= 1'b0;
      hit            <= 1'b0;
      lvl_cnt        <= '0;
      tick           <= '0;
      bus.shift      <= 1'b0;
      bus.rows_clear <= 1'b0;
      bus.score      <= '0;
      bus.level      <= '0;
      bus.playing    <= 1'b0;
      bus.game_over  <= 1'b0;
    end else begin
      key_q          <= bus.key;
      start_q        <= bus.start;
      bus.shift      <= 1'b0;
      bus.rows_clear <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start_rise) begin
            state          <= PLAY;
            bus.rows_clear <= 1'b1;
            bus.playing    <= 1'b1;
            bus.game_over  <= 1'b0;
            bus.score      <= '0;
            bus.level      <= '0;
            hit            <= 1'b0;
            lvl_cnt        <= '0;
            tick           <= CNT_W'(TICK_INIT);
          end
        end
        PLAY: begin
          if (wrong || miss) begin
            state         <= OVER;
            bus.playing   <= 1'b0;
            bus.game_over <= 1'b1;
          end else begin
            if (correct) begin
              hit <= 1'b1;
              if (~&bus.score) bus.score <= bus.score + 1'b1;
              if (lvl_cnt == LC_W'(LEVEL_EVERY - 1)) begin
                lvl_cnt <= '0;
                if (bus.level != 4'd15) bus.level <= bus.level + 4'd1;
              end else begin
                lvl_cnt <= lvl_cnt + 1'b1;
              end
            end
            // Expiry clears the hit flag after it was judged, opening the next tile.
            if (expiry) begin
              bus.shift <= 1'b1;
              hit       <= 1'b0;
              tick      <= period;
            end else begin
              tick <= tick - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tile_game_ctrl.sv
// Self-checking bench for tile_game_ctrl: directed vector table, hand-written
// level/period and corner sequences, then random play against a reference model.
module tb_tile_game_ctrl;
  localparam int TICK_INIT   = 8;
  localparam int TICK_STEP   = 2;
  localparam int TICK_MIN    = 4;
  localparam int LEVEL_EVERY = 2;
  localparam int SCORE_W     = 10;
  localparam int SCORE_MAX   = (1 << SCORE_W) - 1;

  logic clk = 1'b0;
  logic resetn = 1'b1;

  tile_game_ctrl_if #(.SCORE_W(SCORE_W)) bus();

  tile_game_ctrl #(
    .TICK_INIT(TICK_INIT), .TICK_STEP(TICK_STEP), .TICK_MIN(TICK_MIN),
    .LEVEL_EVERY(LEVEL_EVERY), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: game mode, total hits of this game, absolute expiry cycle.
  int         m_mode;       // 0 idle, 1 play, 2 over
  int         m_hits;
  int         m_deadline;
  int         m_cyc;
  bit         m_tile_hit;
  bit         m_shift;
  bit         m_clear;
  logic [3:0] m_key_prev;
  logic       m_start_prev;

  typedef struct {
    int         rep;
    logic       start;
    logic [3:0] key;
    logic [2:0] lane;
    logic       e_shift;
    logic       e_clear;
    logic       e_play;
    logic       e_over;
    int         e_score;
    int         e_level;
  } vec_t;

  vec_t vecs[$];

  function automatic int lvl_of(int hits);
    return (hits / LEVEL_EVERY > 15) ? 15 : hits / LEVEL_EVERY;
  endfunction

  function automatic int period_of(int hits);
    int p;
    p = TICK_INIT - lvl_of(hits) * TICK_STEP;
    return (p < TICK_MIN) ? TICK_MIN : p;
  endfunction

  function automatic int score_of(int hits);
    return (hits > SCORE_MAX) ? SCORE_MAX : hits;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_hits = 0; m_deadline = 0; m_cyc = 0;
    m_tile_hit = 0; m_shift = 0; m_clear = 0;
    m_key_prev = '0; m_start_prev = 1'b0;
  endtask

  // One clock: advance the model on the same inputs the DUT sees, then compare.
  task automatic step();
    logic [3:0] kr;
    bit sr, lane_ok, correct, wrong, expire;
    int lane, hits_before;
    @(posedge clk);
    lane = int'(bus.bottom_lane);
    kr = bus.key & ~m_key_prev;
    sr = bus.start && !m_start_prev;
    m_key_prev = bus.key;
    m_start_prev = bus.start;
    m_shift = 0;
    m_clear = 0;
    lane_ok = (lane >= 1) && (lane <= 4);
    if (m_mode != 1) begin
      if (sr) begin
        m_mode = 1; m_clear = 1; m_hits = 0; m_tile_hit = 0;
        m_deadline = m_cyc + TICK_INIT;
      end
    end else begin
      expire = (m_cyc == m_deadline);
      correct = lane_ok && !m_tile_hit && (kr == (lane_ok ? 4'(1 << (lane - 1)) : 4'd0));
      wrong = (kr != 4'd0) && !correct;
      hits_before = m_hits;
      if (wrong || (expire && lane_ok && !m_tile_hit && !correct)) begin
        m_mode = 2;
      end else begin
        if (correct) begin m_hits++; m_tile_hit = 1; end
        if (expire) begin
          m_shift = 1; m_tile_hit = 0;
          m_deadline = m_cyc + period_of(hits_before);
        end
      end
    end
    m_cyc++;
    #1;
    n_checks++;
    if (bus.shift !== m_shift || bus.rows_clear !== m_clear ||
        int'(bus.score) != score_of(m_hits) || int'(bus.level) != lvl_of(m_hits) ||
        bus.playing !== (m_mode == 1) || bus.game_over !== (m_mode == 2)) begin
      n_fail++;
      $display("FAIL model_cmp cyc=%0d: got shift=%0b clr=%0b score=%0d lvl=%0d play=%0b over=%0b, expected shift=%0b clr=%0b score=%0d lvl=%0d play=%0b over=%0b",
               m_cyc, bus.shift, bus.rows_clear, bus.score, bus.level, bus.playing, bus.game_over,
               m_shift, m_clear, score_of(m_hits), lvl_of(m_hits), m_mode == 1, m_mode == 2);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_shift"}, int'(bus.shift), 0);
    check({tag, "_clear"}, int'(bus.rows_clear), 0);
    check({tag, "_score"}, int'(bus.score), 0);
    check({tag, "_level"}, int'(bus.level), 0);
    check({tag, "_playing"}, int'(bus.playing), 0);
    check({tag, "_over"}, int'(bus.game_over), 0);
  endtask

  task automatic do_reset(input string tag);
    bus.start = 1'b0; bus.key = '0;
    resetn = 1'b0;
    #1;
    check_all_zero(tag);
    model_reset();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic wait_shift(input int bound, output int n);
    n = 0;
    do begin step(); n++; end while (!bus.shift && n < bound);
    check("shift_seen", int'(bus.shift), 1);
  endtask

  task automatic add(input int rep, input logic st, input logic [3:0] k, input logic [2:0] ln,
                     input logic sh, input logic cl, input logic pl, input logic ov,
                     input int sc, input int lv);
    vec_t v;
    v.rep = rep; v.start = st; v.key = k; v.lane = ln;
    v.e_shift = sh; v.e_clear = cl; v.e_play = pl; v.e_over = ov; v.e_score = sc; v.e_level = lv;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, exp_int, lane;
    bus.start = 1'b0; bus.key = '0; bus.bottom_lane = '0;
    #2;
    do_reset("reset");

    //   rep st key lane  sh cl pl ov score lvl
    add(1, 1, 4'h0, 3'd0, 0, 1, 1, 0, 0, 0);   // start edge -> clear pulse
    add(1, 1, 4'h0, 3'd0, 0, 0, 1, 0, 0, 0);
    add(6, 0, 4'h0, 3'd0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 4'h0, 3'd0, 1, 0, 1, 0, 0, 0);   // first shift, 8 cycles after clear
    add(7, 0, 4'h0, 3'd0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 4'h0, 3'd0, 1, 0, 1, 0, 0, 0);
    add(1, 0, 4'h4, 3'd3, 0, 0, 1, 0, 1, 0);   // lane 3 hit
    add(1, 0, 4'h0, 3'd3, 0, 0, 1, 0, 1, 0);
    add(5, 0, 4'h0, 3'd3, 0, 0, 1, 0, 1, 0);
    add(1, 0, 4'h0, 3'd3, 1, 0, 1, 0, 1, 0);   // hit tile shifts normally
    add(1, 0, 4'h4, 3'd3, 0, 0, 1, 0, 2, 1);
    add(1, 0, 4'h0, 3'd3, 0, 0, 1, 0, 2, 1);
    add(1, 0, 4'h4, 3'd3, 0, 0, 0, 1, 2, 1);   // second press on same tile
    add(2, 0, 4'h0, 3'd3, 0, 0, 0, 1, 2, 1);
    add(1, 1, 4'h0, 3'd2, 0, 1, 1, 0, 0, 0);
    add(1, 0, 4'h2, 3'd2, 0, 0, 1, 0, 1, 0);
    add(6, 0, 4'h0, 3'd2, 0, 0, 1, 0, 1, 0);
    add(1, 0, 4'h0, 3'd2, 1, 0, 1, 0, 1, 0);
    add(7, 0, 4'h0, 3'd2, 0, 0, 1, 0, 1, 0);
    add(1, 0, 4'h0, 3'd2, 0, 0, 0, 1, 1, 0);   // missed tile: no shift, score holds
    add(1, 1, 4'h0, 3'd1, 0, 1, 1, 0, 0, 0);
    add(1, 0, 4'h3, 3'd1, 0, 0, 0, 1, 0, 0);   // two keys at once
    add(1, 0, 4'h0, 3'd1, 0, 0, 0, 1, 0, 0);
    add(1, 1, 4'h0, 3'd1, 0, 1, 1, 0, 0, 0);   // restart from OVER
    add(1, 0, 4'h0, 3'd0, 0, 0, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      bus.start = vecs[i].start; bus.key = vecs[i].key; bus.bottom_lane = vecs[i].lane;
      repeat (vecs[i].rep) step();
      check($sformatf("vec%0d_shift", i), int'(bus.shift), int'(vecs[i].e_shift));
      check($sformatf("vec%0d_clear", i), int'(bus.rows_clear), int'(vecs[i].e_clear));
      check($sformatf("vec%0d_playing", i), int'(bus.playing), int'(vecs[i].e_play));
      check($sformatf("vec%0d_over", i), int'(bus.game_over), int'(vecs[i].e_over));
      check($sformatf("vec%0d_score", i), int'(bus.score), vecs[i].e_score);
      check($sformatf("vec%0d_level", i), int'(bus.level), vecs[i].e_level);
    end

    // Level ramp: one hit per tile, period 8,8,6,6,4,... and level saturating at 15.
    do_reset("reset2");
    bus.bottom_lane = 3'd0;
    bus.start = 1'b1; step(); bus.start = 1'b0;
    check("ramp_clear", int'(bus.rows_clear), 1);
    for (int t = 0; t < 32; t++) begin
      bus.bottom_lane = 3'(t % 4 + 1);
      bus.key = 4'(1 << (t % 4)); step();
      bus.key = 4'd0; step();
      exp_int = ((t + 1) / 2 > 15) ? 15 : (t + 1) / 2;
      check($sformatf("ramp%0d_level", t), int'(bus.level), exp_int);
      check($sformatf("ramp%0d_score", t), int'(bus.score), t + 1);
      wait_shift(20, n);
      exp_int = TICK_INIT - ((t / 2 > 15) ? 15 : t / 2) * TICK_STEP;
      if (exp_int < TICK_MIN) exp_int = TICK_MIN;
      check($sformatf("ramp%0d_period", t), n + 2, exp_int);
    end

    // Correct key rising in the very expiry cycle: counted and still shifts.
    bus.bottom_lane = 3'd1;
    repeat (TICK_MIN - 1) step();
    bus.key = 4'd1; step();
    check("expiry_hit_shift", int'(bus.shift), 1);
    check("expiry_hit_score", int'(bus.score), 33);
    check("expiry_hit_playing", int'(bus.playing), 1);
    bus.key = 4'd0; bus.bottom_lane = 3'd0;
    step(); step();
    check("midgame_playing", int'(bus.playing), 1);
    do_reset("midgame_rst");
    repeat (3) step();
    check("after_rst_idle", int'(bus.playing), 0);

    // Random play against the model.
    do_reset("reset3");
    for (int c = 0; c < 3000; c++) begin
      if (m_mode != 1) begin
        bus.key = 4'd0;
        if ($urandom_range(0, 5) == 0) bus.start = ~bus.start;
      end else begin
        if ($urandom_range(0, 30) == 0) bus.start = ~bus.start;
        if (m_shift) bus.bottom_lane = 3'($urandom_range(0, 7));
        lane = int'(bus.bottom_lane);
        if (bus.key != 4'd0) bus.key = 4'd0;
        else if (lane >= 1 && lane <= 4 && !m_tile_hit && $urandom_range(0, 3) == 0)
          bus.key = 4'(1 << (lane - 1));
        else if ($urandom_range(0, 80) == 0)
          bus.key = 4'($urandom_range(1, 15));
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tile_game_ctrl.md
Name: tile_game_ctrl

Overview:
- Game sequencer for the 7-row tile shifter.
- Generates the periodic one-cycle shift pulse and the row-clear pulse.
- Judges lane-key presses against the bottom row's tile code, and tracks score, speed level and game-over.
- Sits between the debounced key inputs and the row shifter; its outputs feed the display/score logic.

Parameters:
TICK_INIT, 25000000, cycles between shifts at level 0
TICK_STEP, 2000000, period reduction per level
TICK_MIN, 5000000, floor on shift period
LEVEL_EVERY, 10, hits per level increment
SCORE_W, 10, score width

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  start/restart request, level signal, rising-edge detected internally
key  in  4  lane keys, active-high, already synchronized/debounced; key[i] = lane i
bottom_lane  in  3  bottom-row tile code: 0 = empty, 1..4 = lane key[code-1], 5..7 = treated as empty
shift  out  1  one-cycle advance pulse to row shifter
rows_clear  out  1  one-cycle pulse; integration drives shifter resetn = resetn & ~rows_clear
score  out  SCORE_W  hit count, saturating at all-ones
level  out  4  speed level, saturating at 15
playing  out  1  high in PLAY
game_over  out  1  high in OVER

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE.
  - shift, rows_clear, score, level, playing and game_over are all 0.
  - Internal state cleared: hit flag, hit-per-level counter, tick counter and key/start edge registers.
- Edge detect:
  - key_rise = key & ~key_q.
  - start_rise = start & ~start_q.
  - Both edge registers update every cycle in all states.
- IDLE:
  - Waits for start_rise.
  - On start_rise: rows_clear=1 for that one cycle; score, level, hit and level counter cleared; tick counter loaded with TICK_INIT; next state PLAY.
- PLAY, tick counter:
  - Decrements by 1 each cycle.
  - Expiry is the cycle in which the counter equals 1.
- PLAY, on expiry:
  - Miss check: if bottom_lane is 1..4 and the hit flag is clear (including a hit registered in this same cycle), the tile is missed. Next state is OVER and no shift is issued.
  - Otherwise: shift=1 for one cycle, hit flag cleared, counter reloaded with the current period.
- Period:
  - period = max(TICK_INIT − level·TICK_STEP, TICK_MIN), computed without underflow.
  - A level change takes effect at the next reload.
- PLAY, key judgement (any cycle with key_rise ≠ 0), evaluated against the current (pre-shift) bottom_lane:
  - Correct: exactly one bit set, bottom_lane in 1..4, key_rise[bottom_lane−1]=1, hit flag clear. Set hit flag, score+1 (saturating) and the level counter +1.
  - When the level counter reaches LEVEL_EVERY: it resets to 0 and level+1 (saturating at 15).
  - Wrong: more than one bit set, wrong lane, empty bottom, or hit flag already set. Next state OVER.
  - A correct hit in the same cycle as expiry counts: score increments and the shift proceeds.
  - Wrong key and expiry in the same cycle: OVER wins, no shift.
- OVER:
  - game_over=1; score and level hold; shift=0.
  - start_rise behaves as in IDLE: rows_clear pulse, clear, go to PLAY.
- A start_rise during PLAY is ignored.
- Reset mid-game: immediate return to IDLE with all outputs 0.
- All outputs are registered; shift and rows_clear are never high for more than one consecutive cycle.

Test Plan:
All scenarios use TICK_INIT=8, TICK_STEP=2, TICK_MIN=4, LEVEL_EVERY=2.
1. Reset, then start pulse with bottom_lane=0 → rows_clear high for 1 cycle; playing=1; shift pulses every 8 cycles; score=0; game_over stays 0.
2. bottom_lane=3, key[2] rises before expiry → score=1; the next expiry shifts normally; a second key[2] rise before the next shift → game_over=1.
3. bottom_lane=2, no key until expiry → no shift on that cycle; game_over=1; score holds its value.
4. Keys 0 and 1 rise together with bottom_lane=1 → OVER; then start pulse → rows_clear, score=0, level=0, playing=1.
5. Four correct hits over successive tiles → level=2; shift period goes 8 → 6 → 4; further levels hold the period at 4; level saturates at 15 after 30 hits.
6. Correct key rise in the same cycle as expiry → score increments and shift=1 that cycle. Separately, resetn asserted mid-PLAY → all outputs 0 asynchronously, state IDLE.
